// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM between instruction fetch and load/store.
// Contested reads use fixed data priority unless ARB_ROUND_ROBIN_EN is defined.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [WIDTH-1:0]      i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_mask,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic [3:0]            mem_mask_write,
    output logic [ADDR_WIDTH-1:0] mem_addr_write,
    output logic [ADDR_WIDTH-1:0] mem_addr_read,
    output logic [WIDTH-1:0]      mem_data_in,
    input  logic [WIDTH-1:0]      mem_data_out
);

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    logic   rd_pending_reg;
    owner_t rd_owner_reg;
    logic   fetch_rd;
    logic   data_rd;
    logic   data_wr;
    logic   fetch_win;
    logic   data_win;
    logic   data_wins_contest;

    // Requests are masked by reset so nothing is granted while reset_n is low.
    always_comb begin
        fetch_rd  = reset_n & i_req;
        data_rd   = reset_n & d_req & ~d_we;
        data_wr   = reset_n & d_req & d_we;
        fetch_win = fetch_rd & (~data_rd | ~data_wins_contest);
        data_win  = data_rd & (~fetch_rd | data_wins_contest);
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic favour_data_reg;

    // Toggles only on contested cycles, so the loser of a contest wins the next.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            favour_data_reg <= 1'b1;
        end else if (fetch_rd && data_rd) begin
            favour_data_reg <= ~favour_data_reg;
        end
    end

    assign data_wins_contest = favour_data_reg;
`else
    assign data_wins_contest = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_reg <= 1'b0;
            rd_owner_reg   <= OWNER_FETCH;
        end else begin
            rd_pending_reg <= fetch_win | data_win;
            if (fetch_win | data_win) begin
                rd_owner_reg <= data_win ? OWNER_DATA : OWNER_FETCH;
            end
        end
    end

    assign i_gnt            = fetch_win;
    assign d_gnt            = data_wr | data_win;
    assign mem_read_enable  = fetch_win | data_win;
    assign mem_addr_read    = data_win ? d_addr : i_addr;
    assign mem_write_enable = data_wr;
    assign mem_addr_write   = d_addr;
    assign mem_mask_write   = d_mask;
    assign mem_data_in      = d_wdata;

    // The RAM registers its read data, so the response simply follows the owner tag.
    assign i_rvalid = rd_pending_reg & (rd_owner_reg == OWNER_FETCH);
    assign d_rvalid = rd_pending_reg & (rd_owner_reg == OWNER_DATA);
    assign i_rdata  = mem_data_out;
    assign d_rdata  = mem_data_out;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic checked
// every cycle against a request-level model (honours ARB_ROUND_ROBIN_EN).
module tb_bram_port_arbiter;
    localparam int AW = 10;
    localparam int W  = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_mask;
    logic [W-1:0]  d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [W-1:0]  i_rdata, d_rdata;
    logic          mem_write_enable, mem_read_enable;
    logic [3:0]    mem_mask_write;
    logic [AW-1:0] mem_addr_write, mem_addr_read;
    logic [W-1:0]  mem_data_in;
    logic [W-1:0]  mem_data_out = '0;

    int checks = 0;
    int errors = 0;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_mask_write(mem_mask_write), .mem_addr_write(mem_addr_write),
        .mem_addr_read(mem_addr_read), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // The RAM, driven only by the DUT's memory port.
    logic [W-1:0] ram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask_write[b]) ram[mem_addr_write][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
        if (mem_read_enable) mem_data_out <= ram[mem_addr_read];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: a separate memory image updated from the requests themselves.
    logic [W-1:0] model_mem [0:(1<<AW)-1];
    bit           m_pend, m_owner_data, m_last_contest_data;
    logic [W-1:0] m_pend_data;
    bit           i_gnt_seen, d_gnt_seen;

    always @(negedge clock) begin
        bit e_ig, e_dwin, e_wr, both;
        e_ig = 0; e_dwin = 0; e_wr = 0; both = 0;
        if (reset_n) begin
            e_wr = d_req && d_we;
            both = i_req && d_req && !d_we;
            if (both) begin
`ifdef ARB_ROUND_ROBIN_EN
                e_ig = m_last_contest_data;
`else
                e_ig = 0;
`endif
                e_dwin = !e_ig;
            end else begin
                e_ig   = i_req;
                e_dwin = d_req && !d_we;
            end
        end
        $display("cyc t=%0t rst_n=%0b ireq=%0b dreq=%0b we=%0b igof=%0b dgnt=%0b irv=%0b drv=%0b",
                 $time, reset_n, i_req, d_req, d_we, i_gnt, d_gnt, i_rvalid, d_rvalid);
        chk("i_gnt", i_gnt, e_ig);
        chk("d_gnt", d_gnt, e_wr || e_dwin);
        chk("mem_read_enable", mem_read_enable, e_ig || e_dwin);
        chk("mem_write_enable", mem_write_enable, e_wr);
        if (e_ig || e_dwin) chk("mem_addr_read", mem_addr_read, e_dwin ? d_addr : i_addr);
        if (e_wr) begin
            chk("mem_addr_write", mem_addr_write, d_addr);
            chk("mem_mask_write", mem_mask_write, d_mask);
            chk("mem_data_in", mem_data_in, d_wdata);
        end
        chk("i_rvalid", i_rvalid, reset_n && m_pend && !m_owner_data);
        chk("d_rvalid", d_rvalid, reset_n && m_pend && m_owner_data);
        if (reset_n && m_pend && !m_owner_data) chk("i_rdata", i_rdata, m_pend_data);
        if (reset_n && m_pend && m_owner_data) chk("d_rdata", d_rdata, m_pend_data);
        i_gnt_seen = i_gnt;
        d_gnt_seen = d_gnt;
        if (!reset_n) begin
            m_pend = 0; m_owner_data = 0; m_last_contest_data = 0;
        end else begin
            m_pend       = e_ig || e_dwin;
            m_owner_data = e_dwin;
            if (both) m_last_contest_data = e_dwin;
            if (e_ig || e_dwin) m_pend_data = model_mem[e_dwin ? d_addr : i_addr];
            if (e_wr)
                for (int b = 0; b < 4; b++)
                    if (d_mask[b]) model_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_mask = '0; d_wdata = '0;
        for (int a = 0; a < (1 << AW); a++) begin
            ram[a] = $urandom;
            model_mem[a] = ram[a];
        end
        ram[10'h010] = 32'hDEADBEEF; model_mem[10'h010] = 32'hDEADBEEF;
        ram[10'h020] = 32'hAABBCCDD; model_mem[10'h020] = 32'hAABBCCDD;
        ram[10'h030] = 32'h30303030; model_mem[10'h030] = 32'h30303030;

        // Reset held with both requesters active.
        i_req = 1; d_req = 1; i_addr = 10'h010; d_addr = 10'h010;
        repeat (2) begin
            @(negedge clock);
            chk("rst_i_gnt", i_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
            chk("rst_rd_en", mem_read_enable, 0); chk("rst_wr_en", mem_write_enable, 0);
            chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
        end
        cyc(); reset_n = 1;
        @(negedge clock); chk("rel_d_gnt", d_gnt, 1); chk("rel_i_gnt", i_gnt, 0);
        cyc(); d_req = 0;
        @(negedge clock); chk("first_d_rvalid", d_rvalid, 1); chk("first_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("fetch_gnt", i_gnt, 1);
        cyc(); i_req = 0;
        @(negedge clock); chk("fetch_rvalid", i_rvalid, 1); chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
        chk("fetch_no_d_rvalid", d_rvalid, 0);

        // Masked write followed by a read of the same word.
        cyc(); d_req = 1; d_we = 1; d_addr = 10'h020; d_mask = 4'b0101; d_wdata = 32'h11223344;
        @(negedge clock); chk("mw_d_gnt", d_gnt, 1); chk("mw_wr_en", mem_write_enable, 1);
        cyc(); d_we = 0;
        @(negedge clock); chk("mr_d_gnt", d_gnt, 1);
        cyc(); d_req = 0;
        @(negedge clock); chk("mr_rvalid", d_rvalid, 1); chk("mr_rdata", d_rdata, 32'hAA22CC44);

        // Fetch and write to the same word in one cycle: fetch sees the old word.
        cyc(); i_req = 1; i_addr = 10'h030;
        d_req = 1; d_we = 1; d_addr = 10'h030; d_mask = 4'hF; d_wdata = 32'h12345678;
        @(negedge clock); chk("cc_i_gnt", i_gnt, 1); chk("cc_d_gnt", d_gnt, 1);
        cyc(); d_req = 0; d_we = 0;
        @(negedge clock); chk("cc_old_rvalid", i_rvalid, 1); chk("cc_old_rdata", i_rdata, 32'h30303030);
        chk("cc_refetch_gnt", i_gnt, 1);
        cyc(); i_req = 0;
        @(negedge clock); chk("cc_new_rdata", i_rdata, 32'h12345678);

        // Fresh reset, then four cycles of contested reads.
        cyc(); reset_n = 0;
        cyc();
        cyc(); reset_n = 1; i_req = 1; i_addr = 10'h020; d_req = 1; d_we = 0; d_addr = 10'h010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
`ifdef ARB_ROUND_ROBIN_EN
            chk("contest_d_gnt", d_gnt, (k % 2 == 0) ? 1 : 0);
            chk("contest_i_gnt", i_gnt, (k % 2 == 0) ? 0 : 1);
`else
            chk("contest_d_gnt", d_gnt, 1);
            chk("contest_i_gnt", i_gnt, 0);
`endif
            cyc();
        end
        i_req = 0; d_req = 0;
        cyc();

        // Reset asserted during the grant cycle of a data read.
        d_req = 1; d_we = 0; d_addr = 10'h020;
        @(negedge clock); chk("mid_d_gnt", d_gnt, 1);
        #2 reset_n = 0;
        cyc(); d_req = 0;
        cyc(); reset_n = 1;
        @(negedge clock); chk("mid_no_rvalid", d_rvalid, 0);
        cyc();
        @(negedge clock); chk("mid_no_rvalid2", d_rvalid, 0);

        // Random traffic; requests are held until granted.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (!i_req || i_gnt_seen) begin
                i_req  = ($urandom_range(0, 9) < 6);
                i_addr = AW'($urandom_range(0, 15));
            end
            if (!d_req || d_gnt_seen) begin
                d_req   = ($urandom_range(0, 9) < 6);
                d_we    = $urandom_range(0, 1);
                d_addr  = AW'($urandom_range(0, 15));
                d_mask  = 4'($urandom);
                d_wdata = $urandom;
            end
        end
        cyc(); i_req = 0; d_req = 0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
